// File: rtl/br_cmp_pkg.sv
// br_cmp_pkg: shared widths and constants for the RV32I branch comparator.
package br_cmp_pkg;
    localparam int XLEN = 32;
    localparam int CELL = 4;
    localparam logic [XLEN-1:0] SIGN_MASK = 32'h8000_0000;
endpackage

// File: rtl/br_cmp_mag_cmp.sv
// mag_cmp: unsigned magnitude comparator built from 4-bit cells merged MSB-first.
module mag_cmp
    import br_cmp_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             eq
);
    localparam int N = WIDTH / CELL;
    // Heap-ordered tree: node k has the more significant child at 2k+1; leaf N-1 is the top nibble.
    logic [2*N-2:0] g;
    logic [2*N-2:0] e;
    always_comb begin
        g = '0;
        e = '0;
        for (int j = 0; j < N; j++) begin
            g[N-1+j] = a[WIDTH-1-CELL*j -: CELL] > b[WIDTH-1-CELL*j -: CELL];
            e[N-1+j] = a[WIDTH-1-CELL*j -: CELL] == b[WIDTH-1-CELL*j -: CELL];
        end
        for (int k = N-2; k >= 0; k--) begin
            g[k] = g[2*k+1] | (e[2*k+1] & g[2*k+2]);
            e[k] = e[2*k+1] & e[2*k+2];
        end
    end
    assign eq = e[0];
    assign lt = ~g[0] & ~e[0];
endmodule

// File: rtl/br_cmp.sv
// br_cmp: RV32I branch comparator with combinational and registered eq/lt results.
module br_cmp
    import br_cmp_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             brun,
    output logic             brlt,
    output logic             breq,
    output logic             brlt_q,
    output logic             breq_q
);
    // Flipping both MSBs maps two's complement order onto unsigned order.
    logic [WIDTH-1:0] m;
    assign m = brun ? '0 : WIDTH'(SIGN_MASK);
    mag_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a (a ^ m),
        .b (b ^ m),
        .lt(brlt),
        .eq(breq)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brlt_q <= 1'b0;
            breq_q <= 1'b0;
        end else begin
            brlt_q <= brlt;
            breq_q <= breq;
        end
    end
endmodule

// File: tb/tb_br_cmp.sv
// tb_br_cmp: directed table, random sweep and reset sequences for br_cmp.
module tb_br_cmp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        brun = 1'b0;
    logic        brlt, breq, brlt_q, breq_q;
    int          checks = 0;
    int          errors = 0;

    br_cmp dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .brun(brun),
        .brlt(brlt), .breq(breq), .brlt_q(brlt_q), .breq_q(breq_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        brun;
        logic        lt;
        logic        eq;
    } vec_t;

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b (a=%h b=%h brun=%b)", name, got, exp, a, b, brun);
        end
    endtask

    initial begin
        vec_t tbl[12];
        logic exp_lt;
        tbl[0]  = '{32'd5,         32'd5,         1'b0, 1'b0, 1'b1};
        tbl[1]  = '{32'd5,         32'd5,         1'b1, 1'b0, 1'b1};
        tbl[2]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{32'd3,         32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{32'd3,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{32'h1234_5677, 32'h1234_5678, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1};

        // Reset state with reset held low.
        #12;
        chk("reset_brlt_q", brlt_q, 1'b0);
        chk("reset_breq_q", breq_q, 1'b0);
        a = 32'd5; b = 32'd5;
        #1;
        chk("comb_in_reset_breq", breq, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            a = tbl[i].a; b = tbl[i].b; brun = tbl[i].brun;
            @(negedge clk);
            chk($sformatf("tbl%0d_brlt", i), brlt, tbl[i].lt);
            chk($sformatf("tbl%0d_breq", i), breq, tbl[i].eq);
            chk($sformatf("tbl%0d_brlt_q", i), brlt_q, tbl[i].lt);
            chk($sformatf("tbl%0d_breq_q", i), breq_q, tbl[i].eq);
        end

        for (int i = 0; i < 1001; i++) begin
            a = $urandom; b = (i % 8 == 0) ? a : $urandom; brun = 1'($urandom_range(0, 1));
            if (i % 16 == 4) b = a ^ 32'h8000_0000;
            #2;
            exp_lt = brun ? (a < b) : ($signed(a) < $signed(b));
            chk("rand_brlt", brlt, exp_lt);
            chk("rand_breq", breq, a == b);
        end

        // One-cycle latency: registered copy holds until the next edge.
        @(negedge clk);
        a = 32'd1; b = 32'd2; brun = 1'b1;
        @(negedge clk);
        chk("lat_brlt_q_loaded", brlt_q, 1'b1);
        a = 32'd7; b = 32'd7;
        #1;
        chk("lat_brlt_q_hold", brlt_q, 1'b1);
        chk("lat_breq_q_hold", breq_q, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_breq_q_loaded", breq_q, 1'b1);

        // Asynchronous reset mid-cycle, combinational outputs unaffected.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_breq_q", breq_q, 1'b0);
        chk("arst_brlt_q", brlt_q, 1'b0);
        chk("arst_breq_comb", breq, 1'b1);
        chk("arst_brlt_comb", brlt, 1'b0);
        a = 32'hFFFF_FFFF; b = 32'd0; brun = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_hold_brlt_q", brlt_q, 1'b0);
        chk("arst_comb_brlt", brlt, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_no_edge_brlt_q", brlt_q, 1'b0);
        @(posedge clk);
        #1;
        chk("rel_brlt_q", brlt_q, 1'b1);
        chk("rel_breq_q", breq_q, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
